// File: rtl/div3_stream_ctrl_pkg.sv
// div3_stream_ctrl_pkg: shared state/remainder encodings and the MSB-first mod-3 step.
package div3_stream_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
   localparam logic [1:0] R0 = 2'b00;
   localparam logic [1:0] R1 = 2'b01;
   localparam logic [1:0] R2 = 2'b10;
   // (2*rem + b) mod 3; the unused code 2'b11 recovers to R0
   function automatic logic [1:0] next_rem(input logic [1:0] rem, input logic b);
      return rem == R0 ? (b ? R1 : R0) :
             rem == R1 ? (b ? R0 : R2) :
             rem == R2 ? (b ? R2 : R1) : R0;
   endfunction
endpackage

// File: rtl/div3_stream_ctrl_if.sv
// div3_stream_ctrl_if: word-in / classification-out valid-ready bundle.
interface div3_stream_ctrl_if #(parameter int W = 8);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_div3;
   logic [1:0]   out_rem;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_div3, out_rem);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_div3, out_rem);
endinterface

// File: rtl/div3_stream_ctrl_mod3_tracker.sv
// mod3_tracker: registered running remainder of an MSB-first bit stream.
module mod3_tracker
   import div3_stream_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [1:0] rem,
   output logic       div3
);
   always_ff @(posedge clk)
      rem <= (rst || clr || rem == 2'b11) ? R0 : en ? next_rem(rem, bit_in) : rem;
   assign div3 = rem == R0;
endmodule

// File: rtl/div3_stream_ctrl.sv
// div3_stream_ctrl: accepts words, shifts them MSB-first through mod3_tracker, reports div-by-3 and remainder.
module div3_stream_ctrl
   import div3_stream_ctrl_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   div3_stream_ctrl_if.slave s,
   output logic          busy,
   output logic [CW-1:0] div_count
);
   localparam int NW = W > 1 ? $clog2(W) : 1;
   localparam logic [NW-1:0] LAST = NW'(W - 1);
   state_t        state, state_n;
   logic [W-1:0]  sr;
   logic [NW-1:0] cnt;
   logic [1:0]    rem;
   logic          div3;
   logic          accept;
   logic          fire;
   assign accept      = s.in_valid && s.in_ready;
   assign fire        = s.out_valid && s.out_ready;
   assign s.in_ready  = state == IDLE;
   assign s.out_valid = state == DONE;
   assign s.out_div3  = state == DONE && div3;
   assign s.out_rem   = state == DONE ? rem : 2'b00;
   assign busy        = state != IDLE;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state == IDLE  ? (s.in_valid ? SHIFT : IDLE) :
                state == SHIFT ? (cnt == '0 ? DONE : SHIFT) :
                state == DONE  ? (s.out_ready ? IDLE : DONE) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         cnt       <= '0;
         div_count <= '0;
      end else begin
         if (accept) begin
            sr  <= s.in_data;
            cnt <= LAST;
         end else if (state == SHIFT) begin
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
         end
         if (fire && s.out_div3 && !(&div_count))
            div_count <= div_count + 1'b1;
      end
   end
   mod3_tracker u_trk (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (state == SHIFT),
      .bit_in (sr[W-1]),
      .rem    (rem),
      .div3   (div3)
   );
endmodule

// File: tb/tb_div3_stream_ctrl.sv
// tb_div3_stream_ctrl: directed + random words checked against an arithmetic mod-3 model.
module tb_div3_stream_ctrl;
   localparam int W  = 8;
   localparam int CW = 2;
   localparam int MAXC = (1 << CW) - 1;
   logic clk = 0;
   logic rst = 1;
   logic busy;
   logic [CW-1:0] div_count;
   int total = 0;
   int bad = 0;
   int exp_count = 0;
   div3_stream_ctrl_if #(.W(W)) bus ();
   div3_stream_ctrl #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (bus),
      .busy      (busy),
      .div_count (div_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Sends one word and holds out_ready low for `hold` cycles while a pending word waits.
   task automatic send(input logic [W-1:0] w, input int hold);
      int lat;
      int exp_rem;
      exp_rem = int'(w) % 3;
      check("idle_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1;
      bus.in_data  = w;
      tick();
      bus.in_valid = 0;
      bus.in_data  = 8'h03;
      check("busy_shift", int'(busy), 1);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      check("latency", lat, W);
      bus.in_valid = hold > 0;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", int'(bus.out_valid), 1);
         check("hold_rem", int'(bus.out_rem), exp_rem);
         check("hold_ready", int'(bus.in_ready), 0);
         tick();
      end
      check("div3", int'(bus.out_div3), int'(exp_rem == 0));
      check("rem", int'(bus.out_rem), exp_rem);
      check("done_busy", int'(busy), 1);
      bus.out_ready = 1;
      tick();
      bus.out_ready = 0;
      bus.in_valid  = 0;
      if (exp_rem == 0 && exp_count < MAXC) exp_count++;
      check("post_valid", int'(bus.out_valid), 0);
      check("post_rem", int'(bus.out_rem), 0);
      check("post_ready", int'(bus.in_ready), 1);
      check("div_count", int'(div_count), exp_count);
   endtask
   initial begin
      bus.in_valid  = 0;
      bus.in_data   = '0;
      bus.out_ready = 0;
      tick();
      tick();
      rst = 0;
      check("rst_ready", int'(bus.in_ready), 1);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_count", int'(div_count), 0);
      check("rst_rem", int'(bus.out_rem), 0);
      send(8'h09, 0);
      send(8'hFF, 0);
      send(8'h64, 0);
      send(8'h02, 0);
      send(8'h00, 5);
      send(8'h03, 0);
      send(8'h03, 0);
      send(8'h03, 0);
      // abort a word mid-shift; nothing may come out and the counter clears
      bus.in_valid = 1;
      bus.in_data  = 8'h06;
      tick();
      bus.in_valid = 0;
      tick();
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0;
      exp_count = 0;
      check("abort_ready", int'(bus.in_ready), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_count", int'(div_count), 0);
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            seen |= int'(bus.out_valid);
            tick();
         end
         check("abort_no_valid", seen, 0);
      end
      for (int i = 0; i < 25; i++)
         send(W'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
